// File: rtl/alu_issue_pkg.sv
// Shared ALU operation codes, instruction class encodings and the issue-stage decode.
// Pure definitions: no state, no latency, no flow control.
package alu_issue_pkg;

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_NOR = 4'b1100;
    localparam logic [3:0] ALUOP_SLL = 4'b1000;

    typedef enum logic [1:0] {
        CLS_MEM    = 2'b00,
        CLS_BRANCH = 2'b01,
        CLS_RTYPE  = 2'b10,
        CLS_RSVD   = 2'b11
    } alu_class_e;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef struct packed {
        logic [3:0] op;
        logic       illegal;
    } decode_t;

    // Anything not explicitly recognised is reported illegal with a zero opcode.
    function automatic decode_t decode_op(input logic [1:0] aluop,
                                          input logic [2:0] funct3,
                                          input logic       funct7_5);
        decode_t d;
        d.op      = ALUOP_AND;
        d.illegal = 1'b1;
        case (alu_class_e'(aluop))
            CLS_MEM: begin
                d.op      = ALUOP_ADD;
                d.illegal = 1'b0;
            end
            CLS_BRANCH: begin
                d.op      = ALUOP_SUB;
                d.illegal = 1'b0;
            end
            CLS_RTYPE: begin
                case (funct3)
                    F3_ADDSUB: begin
                        d.op      = funct7_5 ? ALUOP_SUB : ALUOP_ADD;
                        d.illegal = 1'b0;
                    end
                    F3_AND: begin
                        d.op      = ALUOP_AND;
                        d.illegal = 1'b0;
                    end
                    F3_OR: begin
                        d.op      = ALUOP_OR;
                        d.illegal = 1'b0;
                    end
                    F3_SLL: begin
                        if (!funct7_5) begin
                            d.op      = ALUOP_SLL;
                            d.illegal = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry (main + skid) FIFO; latency 1 from acceptance into an empty buffer to out_valid.
// in_ready is registered not-full, so a release while full frees space only for the next cycle.
module alu_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   count_q, count_d;
    logic         in_ready_q, in_ready_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push, pop;

    assign push = in_valid && in_ready_q && !flush;
    assign pop  = (count_q != 2'd0) && out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = in_data;
                    else                 tail_d = in_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                // Push is only possible below full, so a simultaneous pop leaves exactly one entry.
                2'b11: head_d = in_data;
                default: ;
            endcase
        end
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode + operand select into a 2-entry skid FIFO; latency 1 when empty.
// Backpressure: in_ready drops when both entries are held; outputs hold while out_ready is low.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_aluop,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7_5,
    input  logic              in_alusrc,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [3:0]        out_aluop,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal,
    output logic              err_sticky
);

    localparam int PAY_W = 2 * DATA_W + 4 + TAG_W + 1;

    decode_t           dec;
    logic [DATA_W-1:0] opb;
    logic [PAY_W-1:0]  in_pay;
    logic [PAY_W-1:0]  out_pay;
    logic              err_sticky_q, err_sticky_d;

    assign dec    = decode_op(in_aluop, in_funct3, in_funct7_5);
    assign opb    = in_alusrc ? in_imm : in_rs2_data;
    assign in_pay = {in_rs1_data, opb, dec.op, in_tag, dec.illegal};

    alu_skid_buf #(
        .W (PAY_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pay)
    );

    assign {out_a, out_b, out_aluop, out_tag, out_illegal} = out_pay;

    // Only entries that actually land in the buffer count; a flushed-away entry was never accepted.
    assign err_sticky_d = err_sticky_q | (in_valid & in_ready & ~flush & dec.illegal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_sticky_q <= 1'b0;
        else        err_sticky_q <= err_sticky_d;
    end

    assign err_sticky = err_sticky_q;

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 64, operand width.
REQ-002 The block SHALL have parameter TAG_W, default 5, destination-register tag width.
Ports:
REQ-003 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  upstream (decode) entry valid.
REQ-006 The block SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-007 The block SHALL have port in_aluop  input  2  class: 00 load/store add, 01 branch sub, 10 R-type, 11 reserved.
REQ-008 The block SHALL have port in_funct3  input  3  instruction funct3.
REQ-009 The block SHALL have port in_funct7_5  input  1  instruction bit 30.
REQ-010 The block SHALL have port in_alusrc  input  1  1 = operand b from in_imm, 0 = from in_rs2_data.
REQ-011 The block SHALL have ports in_rs1_data, in_rs2_data, in_imm  input  DATA_W  operand sources.
REQ-012 The block SHALL have port in_tag  input  TAG_W  destination register.
REQ-013 The block SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-014 The block SHALL have port out_valid  output  1  entry presented to the ALU.
REQ-015 The block SHALL have port out_ready  input  1  downstream accepts the entry.
REQ-016 The block SHALL have ports out_a, out_b  output  DATA_W  ALU operands a, b.
REQ-017 The block SHALL have port out_aluop  output  4  ALU operation code.
REQ-018 The block SHALL have port out_tag  output  TAG_W  forwarded in_tag.
REQ-019 The block SHALL have port out_illegal  output  1  presented entry had an undecodable operation.
REQ-020 The block SHALL have port err_sticky  output  1  set when any illegal entry is accepted; cleared only by reset.

Function
REQ-021 The block SHALL decode: aluop 00 -> 0010 (add); 01 -> 0110 (sub); 10 with funct3 000 -> 0010 if funct7_5=0, else 0110; 10/111 -> 0000 (and); 10/110 -> 0001 (or); 10/001 with funct7_5=0 -> 1000 (sll).
REQ-022 The block SHALL treat every other combination, including aluop 11, as illegal: out_aluop 0000, out_illegal 1.
REQ-023 The block SHALL set out_a = in_rs1_data and out_b = in_alusrc ? in_imm : in_rs2_data, captured at acceptance.
REQ-024 The block SHALL accept an entry when in_valid && in_ready, and release one when out_valid && out_ready.
REQ-025 The block SHALL hold a 2-entry FIFO (main + skid); in_ready = not full, registered.
REQ-026 The block SHALL assert out_valid the cycle after acceptance into an empty stage (latency 1).
REQ-027 The block SHALL sustain one entry per cycle while out_ready is held high.
REQ-028 The block SHALL keep out_* stable while out_valid && !out_ready.
REQ-029 The block SHALL deliver entries in acceptance order.
REQ-030 When full, the block SHALL deassert in_ready; a simultaneous release does not accept in the same cycle.
REQ-031 The block SHALL accept and release together when holding exactly one entry; occupancy stays 1.
REQ-032 On flush, the block SHALL empty next cycle; flush beats a same-cycle acceptance, and that entry is dropped.
REQ-033 The block SHALL not change err_sticky on flush.

Reset
REQ-034 While rst_n is low, the block SHALL force, asynchronously: out_valid 0; in_ready 0; out_a, out_b 0; out_aluop 0000; out_tag 0; out_illegal 0; err_sticky 0; occupancy 0.
REQ-035 The block SHALL raise in_ready the first clk edge after rst_n deasserts.
REQ-036 Reset mid-transfer SHALL drop all held entries.

Structure
REQ-037 A shared package SHALL hold the ALUOP constants (AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, SLL 1000) and the 2-bit class encodings, used by this block and the ALU.
REQ-038 The FIFO SHALL be a sub-module alu_skid_buf, parameterised by payload width; decode is combinational in the top.

Verification
REQ-039 aluop=10, funct3=000, funct7_5=1, rs1=10, rs2=3, alusrc=0 -> next cycle out_valid=1, aluop=0110, a=10, b=3.
REQ-040 aluop=00, alusrc=1, imm=0xFFFF_FFFF_FFFF_FFF8, out_ready=1 -> out_b=imm, aluop=0010, one-cycle latency.
REQ-041 out_ready=0, three back-to-back valids -> in_ready drops after two; on out_ready=1 tags appear 1,2,3 in order, none lost.
REQ-042 aluop=11 -> out_aluop=0000, out_illegal=1, err_sticky=1 and stays 1 after flush.
REQ-043 Flush with in_valid=1 while holding 2 entries -> out_valid=0 next cycle, no entries emerge.
REQ-044 rst_n low while out_valid=1 -> all outputs 0 immediately, without a clock edge.
